// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC arbitration and a circular return-address stack.
// The next-PC priority is trap > branch > ret > jump/call > sequential.
// A trap is taken even while the pipeline is stalled.
// The return-address stack (RAS) overwrites its oldest entry when a push finds it full.
// Popping an empty RAS falls back to the sequential PC.
// Both of those RAS cases raise sticky flags that only reset clears.
module pc_unit #(
  parameter int unsigned        WIDTH     = 19,
  parameter logic [WIDTH-1:0]   RESET_VEC = '0,
  parameter logic [WIDTH-1:0]   TRAP_VEC  = 19'h7FF00,
  parameter int unsigned        STEP      = 1,
  parameter int unsigned        RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcwrite,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  input  logic             trap,
  output logic [WIDTH-1:0] pc,
  output logic             redirect,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];

  logic [WIDTH-1:0] pc_seq;
  logic [PTR_W-1:0] top_next;
  logic [PTR_W-1:0] top_prev;
  logic             is_empty;
  logic             is_full;

  assign pc_seq   = pc_q + WIDTH'(STEP);
  assign top_next = (top_q == PTR_LAST) ? '0 : top_q + 1'b1;
  assign top_prev = (top_q == '0) ? PTR_LAST : top_q - 1'b1;
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_FULL);

  // Next-PC arbitration and the RAS push/pop/flag updates that go with the winner.
  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    top_d      = top_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    ras_mem_d  = ras_mem_q;

    if (trap) begin
      pc_d       = TRAP_VEC;
      redirect_d = 1'b1;
    end else if (pcwrite) begin
      if (branch_taken) begin
        pc_d       = branch_target;
        redirect_d = 1'b1;
      end else if (ret) begin
        if (!is_empty) begin
          pc_d       = ras_mem_q[top_q];
          top_d      = top_prev;
          cnt_d      = cnt_q - 1'b1;
          redirect_d = 1'b1;
        end else begin
          // Empty-stack return degrades to a plain sequential step.
          pc_d  = pc_seq;
          unf_d = 1'b1;
        end
      end else if (jump) begin
        pc_d       = jump_target;
        redirect_d = 1'b1;
        if (call) begin
          // When full, top_next lands on the oldest entry, so it is overwritten.
          ras_mem_d[top_next] = pc_seq;
          top_d               = top_next;
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end else begin
        pc_d = pc_seq;
      end
    end
  end

  // Control state: PC, redirect, RAS pointer/count and sticky flags, async-cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_VEC;
      redirect_q <= 1'b0;
      top_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      top_q      <= top_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // RAS storage has no reset; valid entries are tracked by the count alone.
  always_ff @(posedge clk) begin
    ras_mem_q <= ras_mem_d;
  end

  assign pc        = pc_q;
  assign redirect  = redirect_q;
  assign ras_empty = is_empty;
  assign ras_full  = is_full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with default parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcwrite;
  logic        branch_taken;
  logic [18:0] branch_target;
  logic        jump;
  logic [18:0] jump_target;
  logic        call;
  logic        ret;
  logic        trap;
  logic [18:0] pc;
  logic        redirect;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;

  int total = 0;
  int bad   = 0;

  pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .pcwrite      (pcwrite),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .call         (call),
    .ret          (ret),
    .trap         (trap),
    .pc           (pc),
    .redirect     (redirect),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_ovf      (ras_ovf),
    .ras_unf      (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pcwrite = 1'b1; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; call = 1'b0; ret = 1'b0; trap = 1'b0;
  endtask

  task automatic do_jump(input logic [18:0] tgt, input logic is_call);
    idle_inputs();
    jump = 1'b1; jump_target = tgt; call = is_call;
    tick();
  endtask

  task automatic do_ret();
    idle_inputs();
    ret = 1'b1;
    tick();
  endtask

  initial begin
    logic [18:0] call_tgt [5];
    logic [18:0] ret_exp  [4];
    call_tgt = '{19'h0B0, 19'h0C0, 19'h0D0, 19'h0E0, 19'h050};
    ret_exp  = '{19'h0E1, 19'h0D1, 19'h0C1, 19'h0B1};

    idle_inputs();
    pcwrite = 1'b0;
    reset   = 1'b0;
    repeat (5) tick();
    chk("rst_pc", pc, 19'h0);
    chk("rst_redirect", redirect, 0);
    chk("rst_empty", ras_empty, 1);
    chk("rst_full", ras_full, 0);
    chk("rst_ovf", ras_ovf, 0);
    chk("rst_unf", ras_unf, 0);

    reset = 1'b1;
    idle_inputs();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", pc, i);
      chk("seq_redirect", redirect, 0);
    end

    // Stall with a pending jump: nothing moves
    pcwrite = 1'b0; jump = 1'b1; jump_target = 19'h100;
    tick();
    chk("stall_pc", pc, 19'h3);
    chk("stall_redirect", redirect, 0);

    // Trap wins even while stalled
    trap = 1'b1;
    tick();
    chk("trap_pc", pc, 19'h7FF00);
    chk("trap_redirect", redirect, 1);
    idle_inputs();
    tick();
    chk("post_trap_pc", pc, 19'h7FF01);
    chk("post_trap_redirect", redirect, 0);

    // Plain jump, then call/ret round trip
    do_jump(19'h010, 1'b0);
    chk("jump_pc", pc, 19'h010);
    chk("jump_empty", ras_empty, 1);
    do_jump(19'h200, 1'b1);
    chk("call_pc", pc, 19'h200);
    chk("call_empty", ras_empty, 0);
    do_ret();
    chk("ret_pc", pc, 19'h011);
    chk("ret_empty", ras_empty, 1);
    chk("ret_redirect", redirect, 1);

    // Five calls on a 4-deep RAS: A1 is overwritten
    do_jump(19'h0A0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_jump(call_tgt[i], 1'b1);
      if (i == 3) begin
        chk("fill_full", ras_full, 1);
        chk("fill_ovf", ras_ovf, 0);
      end
    end
    chk("ovf_pc", pc, 19'h050);
    chk("ovf_full", ras_full, 1);
    chk("ovf_flag", ras_ovf, 1);
    for (int i = 0; i < 4; i++) begin
      do_ret();
      chk("pop_pc", pc, ret_exp[i]);
    end
    chk("pop_empty", ras_empty, 1);
    chk("pop_unf_clear", ras_unf, 0);
    do_ret();
    chk("unf_pc", pc, 19'h0B2);
    chk("unf_flag", ras_unf, 1);
    chk("unf_redirect", redirect, 0);
    chk("unf_empty", ras_empty, 1);

    // Wrap at the top of the address space
    do_jump(19'h7FFFF, 1'b0);
    idle_inputs();
    tick();
    chk("wrap_pc", pc, 19'h0);
    chk("wrap_redirect", redirect, 0);

    // Branch beats ret and call: no push or pop
    do_jump(19'h400, 1'b1);
    chk("pre_br_empty", ras_empty, 0);
    idle_inputs();
    branch_taken = 1'b1; branch_target = 19'h300;
    ret = 1'b1; jump = 1'b1; call = 1'b1; jump_target = 19'h500;
    tick();
    chk("br_pc", pc, 19'h300);
    chk("br_redirect", redirect, 1);
    chk("br_empty", ras_empty, 0);
    do_ret();
    chk("br_ras_intact", pc, 19'h001);
    chk("br_ras_drained", ras_empty, 1);

    // ret beats jump; trap beats branch
    do_jump(19'h600, 1'b1);
    idle_inputs();
    ret = 1'b1; jump = 1'b1; jump_target = 19'h700;
    tick();
    chk("ret_over_jump", pc, 19'h002);
    idle_inputs();
    trap = 1'b1; branch_taken = 1'b1; branch_target = 19'h123;
    tick();
    chk("trap_over_br", pc, 19'h7FF00);

    // Stall holds flags and RAS
    idle_inputs();
    pcwrite = 1'b0; ret = 1'b1;
    tick();
    chk("stall2_pc", pc, 19'h7FF00);
    chk("stall2_unf", ras_unf, 1);
    chk("stall2_ovf", ras_ovf, 1);

    // Asynchronous reset between edges
    idle_inputs();
    tick();
    #3;
    reset = 1'b0;
    #1;
    chk("async_pc", pc, 19'h0);
    chk("async_redirect", redirect, 0);
    chk("async_ovf", ras_ovf, 0);
    chk("async_unf", ras_unf, 0);
    chk("async_empty", ras_empty, 1);
    chk("async_full", ras_full, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("release_pc", pc, 19'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 19: PC and target width in bits.
REQ-002 Parameter RESET_VEC, default 0: PC value while reset is asserted.
REQ-003 Parameter TRAP_VEC, default 19'h7FF00: PC loaded on trap.
REQ-004 Parameter STEP, default 1: sequential increment.
REQ-005 Parameter RAS_DEPTH, default 4: return-address-stack entries, at least 2.
REQ-006 clk  in  1: single clock; all state updates on the rising edge.
REQ-007 reset  in  1: reset is asynchronous and active-low.
REQ-008 pcwrite  in  1: advance enable; 0 = stall.
REQ-009 branch_taken  in  1, branch_target  in  WIDTH: resolved taken branch.
REQ-010 jump  in  1, jump_target  in  WIDTH: unconditional jump.
REQ-011 call  in  1: qualifies jump as a call; ignored when jump=0.
REQ-012 ret  in  1: return to RAS top.
REQ-013 trap  in  1: redirect to TRAP_VEC.
REQ-014 pc  out  WIDTH: current program counter, registered.
REQ-015 redirect  out  1: registered; high in the cycle after a non-sequential load.
REQ-016 ras_empty  out  1, ras_full  out  1: RAS occupancy flags.
REQ-017 ras_ovf  out  1, ras_unf  out  1: sticky overflow and underflow flags.

Function
REQ-018 Next-PC priority, evaluated each rising edge: trap > branch_taken > ret > jump > sequential (pc+STEP).
REQ-019 trap loads TRAP_VEC regardless of pcwrite.
REQ-020 All other sources act only when pcwrite=1; pcwrite=0 with trap=0: pc, RAS and all flags hold, and redirect=0 next cycle.
REQ-021 Latency is one edge: the selected value appears on pc after the edge that sampled the inputs.
REQ-022 Arithmetic is mod 2^WIDTH; pc+STEP wraps silently (19'h7FFFF+1 -> 0).
REQ-023 redirect=1 after loads from trap, branch, jump or a successful ret; redirect=0 after sequential, stall, or an underflowed ret.
REQ-024 Push happens only when jump & call win arbitration: push value is pc+STEP (current pc), and pc loads jump_target.
REQ-025 Pop happens only when ret wins arbitration and the RAS is non-empty: pc loads the top entry.
REQ-026 ret on empty RAS: pc takes the sequential value, ras_unf is set, and occupancy is unchanged.
REQ-027 Push on full RAS: the oldest entry is overwritten (circular), count stays RAS_DEPTH, and ras_ovf is set.
REQ-028 When a higher-priority source wins (trap or branch), any asserted ret, jump or call is dropped, with no push or pop.
REQ-029 ras_empty = (count==0) and ras_full = (count==RAS_DEPTH), both registered with the state.
REQ-030 ras_ovf and ras_unf clear only on reset.
REQ-031 RAS state comprises RAS_DEPTH x WIDTH storage, a top pointer and a count of width clog2(RAS_DEPTH+1).

Reset
REQ-032 While reset=0: pc=RESET_VEC, redirect=0, count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0.
REQ-033 Assertion takes effect immediately, without a clock edge, including mid-operation.
REQ-034 After release, the first edge with pcwrite=1 gives pc=RESET_VEC+STEP.
REQ-035 RAS storage contents need not be cleared; only the pointers and count are cleared.

Verification (WIDTH=19, STEP=1, RESET_VEC=0, TRAP_VEC=7FF00, RAS_DEPTH=4)
REQ-036 Hold reset=0 for 5 cycles, release, set pcwrite=1 for 3 edges -> pc = 0, then 1, 2, 3; redirect stays 0.
REQ-037 Set pcwrite=0 with jump=1 and jump_target=100 -> pc holds.
REQ-038 Then assert trap=1 with pcwrite=0 -> pc=7FF00 and redirect=1 for one cycle.
REQ-039 At pc=10, assert jump=call=1 with target 200 -> pc=200 and ras_empty=0.
REQ-040 Then ret -> pc=11, ras_empty=1 and redirect=1.
REQ-041 Issue 5 calls from pc=A0,B0,C0,D0,E0 -> ras_full=1 and ras_ovf=1.
REQ-042 Then 4 rets -> pc = E1, D1, C1, B1.
REQ-043 Then a 5th ret -> pc=B2, ras_unf=1 and redirect=0.
REQ-044 At pc=7FFFF, sequential -> 00000.
REQ-045 Assert branch_taken with target 300 plus ret and jump=call=1 on a non-empty RAS -> pc=300 and RAS count unchanged.
REQ-046 Drop reset between clock edges mid-run -> pc=0 and all flags cleared before the next edge.
